// File: rtl/treeval_sched.sv
// Round-robin front end sharing one treeval unit among NUM_REQ message sources.
// Optional run/timeout statistics ports are enabled by defining TREEVAL_SCHED_STATS_EN.
module treeval_sched #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned W_MSG          = 64,
  parameter int unsigned W_ADDR         = 10,
  parameter int unsigned MAX_DATA_WIDTH = 10,
  parameter int unsigned W_REWARD       = 10,
  parameter int unsigned W_ACTION       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_rdy,
  input  logic [NUM_REQ*W_MSG-1:0]    req_msg,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [NUM_REQ-1:0]          rsp_rdy,
  output logic [W_MSG-1:0]            rsp_msg,
  input  logic [NUM_REQ-1:0]          rsp_ack,
  output logic                        tv_rst,
  output logic                        tv_mem_par,
  output logic                        tv_mem_act,
  output logic                        tv_mem_rew,
  output logic                        tv_mem_weight,
  output logic [W_ADDR-1:0]           tv_mem_addr,
  output logic [MAX_DATA_WIDTH-1:0]   tv_mem_data,
  output logic                        tv_conf_nodes,
  output logic [MAX_DATA_WIDTH-1:0]   tv_conf_data,
  input  logic                        tv_exp_change,
  input  logic [W_REWARD-1:0]         tv_exp,
  input  logic [W_ACTION-1:0]         tv_act,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  owner
`ifdef TREEVAL_SCHED_STATS_EN
  ,
  output logic [15:0]                 run_count,
  output logic [15:0]                 timeout_count
`endif
);

  localparam int unsigned W_OWN = $clog2(NUM_REQ);
  localparam int unsigned W_CNT = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned W_PAD = W_MSG - 2 - W_ACTION - W_REWARD;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {C_RUN = 2'd0, C_NODE = 2'd1, C_CONF = 2'd2, C_ILL = 2'd3} cmd_t;

  state_t r_state, w_state_nxt;

  logic [W_OWN-1:0]          r_ptr, r_owner;
  logic [NUM_REQ-1:0]        r_ack;
  cmd_t                      r_cmd;
  logic [W_ADDR-1:0]         r_addr;
  logic [1:0]                r_field, r_sub;
  logic [MAX_DATA_WIDTH-1:0] r_data;
  logic                      r_par, r_act_s, r_rew, r_weight, r_conf, r_tvrst;
  logic [W_ADDR-1:0]         r_maddr;
  logic [MAX_DATA_WIDTH-1:0] r_mdata, r_cdata;
  logic [W_CNT-1:0]          r_cnt;
  logic [1:0]                r_status;
  logic [W_REWARD-1:0]       r_exp;
  logic [W_ACTION-1:0]       r_act;

  logic                      w_hi_vld, w_lo_vld, w_any;
  logic [W_OWN-1:0]          w_hi_idx, w_lo_idx, w_gnt_idx;
  logic [NUM_REQ-1:0]        w_gnt_oh, w_own_oh;
  logic [W_MSG-1:0]          w_gnt_msg;
  logic                      w_unused_msg;
  logic                      w_illegal, w_grant, w_start_run, w_done, w_tmo;

  // Rotating priority: lowest ready index at or above r_ptr, else lowest overall.
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_vld = 1'b0;
    w_lo_idx = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req_rdy[i-1]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = W_OWN'(i - 1);
        if ((i - 1) >= 32'(r_ptr)) begin
          w_hi_vld = 1'b1;
          w_hi_idx = W_OWN'(i - 1);
        end
      end
    end
    w_any     = w_lo_vld;
    w_gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_gnt_msg = '0;
    w_gnt_oh  = '0;
    w_own_oh  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i] = (w_gnt_idx == W_OWN'(i));
      w_own_oh[i] = (r_owner == W_OWN'(i));
      if (w_gnt_idx == W_OWN'(i)) w_gnt_msg = req_msg[i*W_MSG +: W_MSG];
    end
  end

  assign w_unused_msg = ^w_gnt_msg;
  assign w_illegal    = (r_cmd == C_ILL) || ((r_cmd == C_CONF) && (r_sub != 2'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_start_run = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    busy        = (r_state != S_IDLE);
    rsp_rdy     = '0;
    rsp_msg     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_illegal) begin
          w_state_nxt = S_RESP;
        end else if (r_cmd == C_RUN) begin
          w_start_run = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        // Completion takes precedence over a timeout landing on the same cycle.
        if (tv_exp_change) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == W_CNT'(TIMEOUT_CYCLES - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_rdy = w_own_oh;
        rsp_msg = {r_status, {W_PAD{1'b0}}, r_act, r_exp};
        if (|(rsp_ack & w_own_oh)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_ack    <= '0;
      r_cmd    <= C_RUN;
      r_addr   <= '0;
      r_field  <= '0;
      r_sub    <= '0;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_act_s  <= 1'b0;
      r_rew    <= 1'b0;
      r_weight <= 1'b0;
      r_conf   <= 1'b0;
      r_tvrst  <= 1'b0;
      r_maddr  <= '0;
      r_mdata  <= '0;
      r_cdata  <= '0;
      r_cnt    <= '0;
      r_status <= '0;
      r_exp    <= '0;
      r_act    <= '0;
    end else begin
      r_ack <= w_grant ? w_gnt_oh : '0;
      if (w_grant) begin
        r_owner <= w_gnt_idx;
        r_ptr   <= (w_gnt_idx == W_OWN'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_cmd   <= cmd_t'(w_gnt_msg[W_MSG-1 -: 2]);
        r_addr  <= w_gnt_msg[W_MSG-3 -: W_ADDR];
        r_field <= w_gnt_msg[W_MSG-3-W_ADDR -: 2];
        r_sub   <= w_gnt_msg[W_MSG-3 -: 2];
        r_data  <= w_gnt_msg[MAX_DATA_WIDTH-1:0];
      end

      r_par    <= 1'b0;
      r_act_s  <= 1'b0;
      r_rew    <= 1'b0;
      r_weight <= 1'b0;
      r_conf   <= 1'b0;
      r_maddr  <= '0;
      r_mdata  <= '0;
      r_cdata  <= '0;
      if (r_state == S_ISSUE && r_cmd == C_NODE) begin
        r_par    <= (r_field == 2'd0);
        r_act_s  <= (r_field == 2'd1);
        r_rew    <= (r_field == 2'd2);
        r_weight <= (r_field == 2'd3);
        r_maddr  <= r_addr;
        r_mdata  <= r_data;
      end
      if (r_state == S_ISSUE && r_cmd == C_CONF && !w_illegal) begin
        r_conf  <= 1'b1;
        r_cdata <= r_data;
      end

      r_tvrst <= w_start_run;
      if (w_start_run)            r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;

      if (r_state == S_ISSUE && w_illegal) begin
        r_status <= 2'd2;
        r_exp    <= '0;
        r_act    <= '0;
      end else if (w_done) begin
        r_status <= 2'd0;
        r_exp    <= tv_exp;
        r_act    <= tv_act;
      end else if (w_tmo) begin
        r_status <= 2'd1;
        r_exp    <= '0;
        r_act    <= '0;
      end
    end
  end

  assign req_ack       = r_ack;
  assign owner         = r_owner;
  assign tv_rst        = r_tvrst;
  assign tv_mem_par    = r_par;
  assign tv_mem_act    = r_act_s;
  assign tv_mem_rew    = r_rew;
  assign tv_mem_weight = r_weight;
  assign tv_mem_addr   = r_maddr;
  assign tv_mem_data   = r_mdata;
  assign tv_conf_nodes = r_conf;
  assign tv_conf_data  = r_cdata;

`ifdef TREEVAL_SCHED_STATS_EN
  logic [15:0] r_run_cnt, r_tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      if (w_start_run && r_run_cnt != '1) r_run_cnt <= r_run_cnt + 1'b1;
      if (w_tmo && r_tmo_cnt != '1)       r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign run_count     = r_run_cnt;
  assign timeout_count = r_tmo_cnt;
`endif

endmodule

// File: tb/tb_treeval_sched.sv
// Directed bench for treeval_sched: two requesters, 16-cycle timeout.
// Statistics checks are compiled in when TREEVAL_SCHED_STATS_EN is defined.
module tb_treeval_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_rdy;
  logic [127:0] req_msg;
  logic [1:0]   req_ack;
  logic [1:0]   rsp_rdy;
  logic [63:0]  rsp_msg;
  logic [1:0]   rsp_ack;
  logic         tv_rst, tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight;
  logic [9:0]   tv_mem_addr, tv_mem_data, tv_conf_data;
  logic         tv_conf_nodes;
  logic         tv_exp_change;
  logic [9:0]   tv_exp;
  logic [2:0]   tv_act;
  logic         busy;
  logic         owner;
`ifdef TREEVAL_SCHED_STATS_EN
  logic [15:0]  run_count, timeout_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [105:0] all_outs;
  assign all_outs = {req_ack, rsp_rdy, rsp_msg, tv_rst, tv_mem_par, tv_mem_act, tv_mem_rew,
                     tv_mem_weight, tv_mem_addr, tv_mem_data, tv_conf_nodes, tv_conf_data,
                     busy, owner};

  treeval_sched #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_rdy       (req_rdy),
    .req_msg       (req_msg),
    .req_ack       (req_ack),
    .rsp_rdy       (rsp_rdy),
    .rsp_msg       (rsp_msg),
    .rsp_ack       (rsp_ack),
    .tv_rst        (tv_rst),
    .tv_mem_par    (tv_mem_par),
    .tv_mem_act    (tv_mem_act),
    .tv_mem_rew    (tv_mem_rew),
    .tv_mem_weight (tv_mem_weight),
    .tv_mem_addr   (tv_mem_addr),
    .tv_mem_data   (tv_mem_data),
    .tv_conf_nodes (tv_conf_nodes),
    .tv_conf_data  (tv_conf_data),
    .tv_exp_change (tv_exp_change),
    .tv_exp        (tv_exp),
    .tv_act        (tv_act),
    .busy          (busy),
    .owner         (owner)
`ifdef TREEVAL_SCHED_STATS_EN
    ,
    .run_count     (run_count),
    .timeout_count (timeout_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_node(input logic [9:0] a, input logic [1:0] f,
                                          input logic [9:0] d);
    logic [63:0] m;
    m = '0;
    m[63:62] = 2'b01;
    m[61:52] = a;
    m[51:50] = f;
    m[9:0]   = d;
    return m;
  endfunction

  function automatic logic [63:0] mk_conf(input logic [1:0] sub, input logic [9:0] d);
    logic [63:0] m;
    m = '0;
    m[63:62] = 2'b10;
    m[61:60] = sub;
    m[9:0]   = d;
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input bit ok);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $error("FAIL %s", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_rdy = '0; req_msg = '0; rsp_ack = '0;
    tv_exp_change = 1'b0; tv_exp = '0; tv_act = '0;
    tick(); tick();
    chk("reset_outputs", all_outs === 106'd0);
    rst = 1'b0;

    req_msg[63:0] = mk_node(10'd5, 2'd2, 10'h07F);
    req_rdy = 2'b01;
    tick();
    chk("node_ack", req_ack === 2'b01);
    chk("node_busy", busy === 1'b1);
    chk("node_strobe_early", tv_mem_rew === 1'b0);
    req_rdy = 2'b00;
    tick();
    chk("node_strobes", {tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight} === 4'b0010);
    chk("node_addr", tv_mem_addr === 10'd5);
    chk("node_data", tv_mem_data === 10'h07F);
    chk("node_ack_off", req_ack === 2'b00);
    tick();
    chk("node_strobes_off", {tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight} === 4'b0000);
    chk("node_addr_off", tv_mem_addr === 10'd0);
    chk("node_idle", busy === 1'b0);

    req_msg[63:0]   = mk_conf(2'd0, 10'h011);
    req_msg[127:64] = mk_conf(2'd0, 10'h022);
    req_rdy = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_ack", req_ack === (((k % 2) == 0) ? 2'b10 : 2'b01));
      if (k == 3) req_rdy = 2'b00;
      tick();
      chk("rr_conf", tv_conf_nodes === 1'b1);
      chk("rr_conf_data", tv_conf_data === (((k % 2) == 0) ? 10'h022 : 10'h011));
    end
    tick();
    chk("rr_conf_off", tv_conf_nodes === 1'b0);
    chk("rr_no_ack", req_ack === 2'b00);

    req_msg[127:64] = 64'h0;
    req_rdy = 2'b10;
    tick();
    chk("run_ack", req_ack === 2'b10);
    chk("run_owner", owner === 1'b1);
    req_rdy = 2'b00;
    tick();
    chk("run_tvrst", tv_rst === 1'b1);
    tick();
    chk("run_tvrst_off", tv_rst === 1'b0);
    repeat (8) tick();
    chk("run_no_rsp_yet", rsp_rdy === 2'b00);
    tv_exp_change = 1'b1; tv_exp = 10'h3FD; tv_act = 3'd4;
    tick();
    tv_exp_change = 1'b0;
    chk("run_rsp_rdy", rsp_rdy === 2'b10);
    chk("run_rsp_msg", rsp_msg === 64'h0000_0000_0000_13FD);
    repeat (3) tick();
    chk("run_rsp_hold", rsp_rdy === 2'b10);
    chk("run_rsp_msg_hold", rsp_msg === 64'h0000_0000_0000_13FD);
    rsp_ack = 2'b10;
    tick();
    chk("run_rsp_clear", rsp_rdy === 2'b00);
    chk("run_idle", busy === 1'b0);
    chk("run_msg_clear", rsp_msg === 64'h0);
    rsp_ack = 2'b00;

    tv_exp_change = 1'b1; tv_exp = 10'h155;
    tick();
    tv_exp_change = 1'b0;
    chk("stray_done_busy", busy === 1'b0);
    chk("stray_done_rsp", rsp_rdy === 2'b00);

    req_rdy = 2'b10;
    tick();
    chk("tmo_ack", req_ack === 2'b10);
    req_rdy = 2'b01;
    req_msg[63:0] = mk_node(10'h3FF, 2'd3, 10'h2AA);
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk("tmo_wait_no_grant", req_ack === 2'b00);
      chk("tmo_wait_no_rsp", rsp_rdy === 2'b00);
    end
    tick();
    chk("tmo_rsp_rdy", rsp_rdy === 2'b10);
    chk("tmo_rsp_msg", rsp_msg === 64'h4000_0000_0000_0000);
    chk("tmo_pending_not_granted", req_ack === 2'b00);
    rsp_ack = 2'b10;
    tick();
    chk("tmo_rsp_clear", rsp_rdy === 2'b00);
    chk("tmo_still_no_grant", req_ack === 2'b00);
    rsp_ack = 2'b00;
    tick();
    chk("tmo_pending_grant", req_ack === 2'b01);
    chk("tmo_pending_owner", owner === 1'b0);
    req_rdy = 2'b00;
    tick();
    chk("weight_strobes", {tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight} === 4'b0001);
    chk("weight_addr", tv_mem_addr === 10'h3FF);
    chk("weight_data", tv_mem_data === 10'h2AA);

    req_msg[63:0] = 64'h0;
    req_rdy = 2'b01;
    tick();
    chk("race_ack", req_ack === 2'b01);
    req_rdy = 2'b00;
    repeat (16) tick();
    chk("race_no_rsp_yet", rsp_rdy === 2'b00);
    tv_exp_change = 1'b1; tv_exp = 10'h1FF; tv_act = 3'd7;
    tick();
    tv_exp_change = 1'b0;
    chk("race_rsp_rdy", rsp_rdy === 2'b01);
    chk("race_rsp_msg", rsp_msg === 64'h0000_0000_0000_1DFF);
    rsp_ack = 2'b01;
    tick();
    chk("race_rsp_clear", rsp_rdy === 2'b00);
    rsp_ack = 2'b00;
`ifdef TREEVAL_SCHED_STATS_EN
    chk("stats_runs", run_count === 16'd3);
    chk("stats_timeouts", timeout_count === 16'd1);
`endif

    req_msg[63:0] = 64'hC000_0000_0000_0123;
    req_rdy = 2'b01;
    tick();
    chk("ill_ack", req_ack === 2'b01);
    req_rdy = 2'b00;
    tick();
    chk("ill_rsp_rdy", rsp_rdy === 2'b01);
    chk("ill_rsp_msg", rsp_msg === 64'h8000_0000_0000_0000);
    chk("ill_no_strobes", {tv_rst, tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight, tv_conf_nodes} === 6'b000000);
    rsp_ack = 2'b10;
    tick();
    chk("ill_wrong_ack_ignored", rsp_rdy === 2'b01);
    chk("ill_no_strobes_2", {tv_rst, tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight, tv_conf_nodes} === 6'b000000);
    rsp_ack = 2'b01;
    tick();
    chk("ill_rsp_clear", rsp_rdy === 2'b00);
    chk("ill_idle", busy === 1'b0);
    rsp_ack = 2'b00;

    req_msg[127:64] = mk_conf(2'd1, 10'h005);
    req_rdy = 2'b10;
    tick();
    chk("badconf_ack", req_ack === 2'b10);
    req_rdy = 2'b00;
    tick();
    chk("badconf_rsp_rdy", rsp_rdy === 2'b10);
    chk("badconf_rsp_msg", rsp_msg === 64'h8000_0000_0000_0000);
    chk("badconf_no_conf", {tv_conf_nodes, tv_conf_data} === 11'd0);
    rsp_ack = 2'b10;
    tick();
    chk("badconf_rsp_clear", rsp_rdy === 2'b00);
    rsp_ack = 2'b00;

    req_msg[63:0] = 64'h0;
    req_rdy = 2'b01;
    tick();
    chk("abort_ack", req_ack === 2'b01);
    req_rdy = 2'b00;
    tick(); tick(); tick();
    chk("abort_busy", busy === 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", all_outs === 106'd0);
    tick();
    chk("abort_outputs_held", all_outs === 106'd0);
    rst = 1'b0;
    req_msg[63:0]   = mk_node(10'd1, 2'd0, 10'd1);
    req_msg[127:64] = mk_node(10'd2, 2'd1, 10'd2);
    req_rdy = 2'b11;
    tick();
    chk("post_rst_ack", req_ack === 2'b01);
    chk("post_rst_owner", owner === 1'b0);
    chk("post_rst_no_rsp", rsp_rdy === 2'b00);
    req_rdy = 2'b00;
    tick();
    chk("post_rst_strobes", {tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight} === 4'b1000);
    chk("post_rst_addr", tv_mem_addr === 10'd1);
    chk("post_rst_data", tv_mem_data === 10'd1);
`ifdef TREEVAL_SCHED_STATS_EN
    chk("stats_runs_reset", run_count === 16'd0);
    chk("stats_timeouts_reset", timeout_count === 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
